// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side handshakes around mem_port_arbiter.
// The arbiter takes the slave modport; the pipeline/memory environment takes master.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_abort;
  logic [DW-1:0] if_rdata;
  logic          if_ack;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ack;

  logic          stall_F;
  logic          stall_M;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  modport slave (
    input  if_req, if_addr, if_abort,
    output if_rdata, if_ack,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_rdata, dm_ack,
    output stall_F, stall_M,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport master (
    output if_req, if_addr, if_abort,
    input  if_rdata, if_ack,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_rdata, dm_ack,
    input  stall_F, stall_M,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and data; `define ARB_ROUND_ROBIN_EN for alternating grants.
// Request-to-ack is 2 cycles plus one per mem_ready=0 wait; requesters are held off through stall_F/stall_M.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic             clk,
  input  logic             rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  state_t        r_state;
  logic          r_mem_en;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_dm_rdata;
  logic          r_if_ack;
  logic          r_dm_ack;
  logic          r_drop;

  logic          w_if_vld;
  logic          w_grant_d;
  logic          w_drop;

  assign w_if_vld = bus.if_req & ~bus.if_abort;
  // An abort in the completing cycle must still suppress the ack.
  assign w_drop   = r_drop | bus.if_abort;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_d;
  assign w_grant_d = bus.dm_req & (~w_if_vld | ~r_last_d);
`else
  assign w_grant_d = bus.dm_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_if_ack    <= 1'b0;
      r_dm_ack    <= 1'b0;
      r_drop      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_d    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_state     <= BUSY_D;
            r_mem_en    <= 1'b1;
            r_mem_we    <= bus.dm_we;
            r_mem_addr  <= bus.dm_addr;
            r_mem_wdata <= bus.dm_wdata;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_d    <= 1'b1;
`endif
          end else if (w_if_vld) begin
            r_state    <= BUSY_I;
            r_mem_en   <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= bus.if_addr;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_d   <= 1'b0;
`endif
          end
        end
        BUSY_I: begin
          r_drop <= w_drop;
          if (bus.mem_ready) begin
            r_state  <= RESP;
            r_mem_en <= 1'b0;
            r_if_ack <= ~w_drop;
            if (!w_drop) begin
              r_if_rdata <= bus.mem_rdata;
            end
          end
        end
        BUSY_D: begin
          if (bus.mem_ready) begin
            r_state  <= RESP;
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            r_dm_ack <= 1'b1;
            if (!r_mem_we) begin
              r_dm_rdata <= bus.mem_rdata;
            end
          end
        end
        RESP: begin
          r_state  <= IDLE;
          r_if_ack <= 1'b0;
          r_dm_ack <= 1'b0;
          r_drop   <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.dm_rdata  = r_dm_rdata;
  assign bus.if_ack    = r_if_ack;
  assign bus.dm_ack    = r_dm_ack;

  assign bus.stall_F = bus.if_req & ~r_if_ack & ~bus.if_abort;
  assign bus.stall_M = bus.dm_req & ~r_dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed vector table for the documented scenarios, then randomized traffic
// checked against a transaction-level requester/memory model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus();
  mem_port_arbiter #(.AW(32), .DW(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_ok(input string name, input bit ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got condition false expected true", name);
    end
  endtask

  typedef struct {
    logic        rst, ireq, iab, dreq, dwe, rdy;
    logic [31:0] iaddr, daddr, dwd, rdata;
    logic        en, we, ia, da, sf, sm;
    logic [31:0] maddr, mwd, ir, dr;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] e_maddr, e_mwd, e_ir, e_dr;

  task automatic row(input logic rs, ireq, input logic [31:0] iaddr, input logic iab, dreq, dwe,
                     input logic [31:0] daddr, dwd, input logic rdy, input logic [31:0] rdata,
                     input logic en, we, ia, da, sf, sm);
    vec_t v;
    v.rst = rs; v.ireq = ireq; v.iaddr = iaddr; v.iab = iab;
    v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd;
    v.rdy = rdy; v.rdata = rdata;
    v.en = en; v.we = we; v.ia = ia; v.da = da; v.sf = sf; v.sm = sm;
    v.maddr = e_maddr; v.mwd = e_mwd; v.ir = e_ir; v.dr = e_dr;
    vecs.push_back(v);
  endtask

  task automatic idle_row(input logic en, ia, da);
    row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, en, 0, ia, da, 0, 0);
  endtask

  // Transaction-level model state for the random phase.
  logic [31:0] tmem[256];
  logic [31:0] ref_mem[256];
  bit          f_pend, d_pend, d_block, d_we, prev_en, prev_dreq, done;
  logic [31:0] f_addr, d_addr, d_wd, exp_ir, exp_dr, p_addr, p_wd;
  logic        p_we;
  int          f_wait, d_wait;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    e_maddr = 0; e_mwd = 0; e_ir = 0; e_dr = 0;
    // Fetch 0x40, ready on first BUSY cycle.
    row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,                      0, 0, 0, 0, 0, 0);
    row(0, 1, 'h40, 0, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 0, 1, 0);
    e_maddr = 'h40;
    row(0, 1, 'h40, 0, 0, 0, 0, 0, 1, 'h8C220004,          1, 0, 0, 0, 1, 0);
    e_ir = 'h8C220004;
    row(0, 1, 'h40, 0, 0, 0, 0, 0, 0, 0,                   0, 0, 1, 0, 0, 0);
    idle_row(0, 0, 0);
    // Store 0x100 with three wait cycles; store must not touch dm_rdata.
    row(0, 0, 0, 0, 1, 1, 'h100, 'hDEADBEEF, 0, 0,         0, 0, 0, 0, 0, 1);
    e_maddr = 'h100; e_mwd = 'hDEADBEEF;
    for (int k = 0; k < 3; k++)
      row(0, 0, 0, 0, 1, 1, 'h100, 'hDEADBEEF, 0, 0,       1, 1, 0, 0, 0, 1);
    row(0, 0, 0, 0, 1, 1, 'h100, 'hDEADBEEF, 1, 'h55AA55AA, 1, 1, 0, 0, 0, 1);
    row(0, 0, 0, 0, 1, 1, 'h100, 'hDEADBEEF, 0, 0,         0, 0, 0, 1, 0, 0);
    idle_row(0, 0, 0);
    // Simultaneous fetch 0x80 and load 0x200.
`ifdef ARB_ROUND_ROBIN_EN
    row(0, 1, 'h80, 0, 1, 0, 'h200, 0, 0, 0,               0, 0, 0, 0, 1, 1);
    e_maddr = 'h80;
    row(0, 1, 'h80, 0, 1, 0, 'h200, 0, 1, 'hA5A5A5A5,      1, 0, 0, 0, 1, 1);
    e_ir = 'hA5A5A5A5;
    row(0, 1, 'h80, 0, 1, 0, 'h200, 0, 0, 0,               0, 0, 1, 0, 0, 1);
    row(0, 0, 0, 0, 1, 0, 'h200, 0, 0, 0,                  0, 0, 0, 0, 0, 1);
    e_maddr = 'h200; e_mwd = 0;
    row(0, 0, 0, 0, 1, 0, 'h200, 0, 1, 'h12345678,         1, 0, 0, 0, 0, 1);
    e_dr = 'h12345678;
    row(0, 0, 0, 0, 1, 0, 'h200, 0, 0, 0,                  0, 0, 0, 1, 0, 0);
    idle_row(0, 0, 0);
`else
    row(0, 1, 'h80, 0, 1, 0, 'h200, 0, 0, 0,               0, 0, 0, 0, 1, 1);
    e_maddr = 'h200; e_mwd = 0;
    row(0, 1, 'h80, 0, 1, 0, 'h200, 0, 1, 'h12345678,      1, 0, 0, 0, 1, 1);
    e_dr = 'h12345678;
    row(0, 1, 'h80, 0, 1, 0, 'h200, 0, 0, 0,               0, 0, 0, 1, 1, 0);
    row(0, 1, 'h80, 0, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 0, 1, 0);
    e_maddr = 'h80;
    row(0, 1, 'h80, 0, 0, 0, 0, 0, 1, 'hA5A5A5A5,          1, 0, 0, 0, 1, 0);
    e_ir = 'hA5A5A5A5;
    row(0, 1, 'h80, 0, 0, 0, 0, 0, 0, 0,                   0, 0, 1, 0, 0, 0);
    idle_row(0, 0, 0);
`endif
    // Fetch 0xC0 aborted in the second wait cycle: no ack, if_rdata kept.
    row(0, 1, 'hC0, 0, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 0, 1, 0);
    e_maddr = 'hC0;
    row(0, 1, 'hC0, 0, 0, 0, 0, 0, 0, 0,                   1, 0, 0, 0, 1, 0);
    row(0, 1, 'hC0, 1, 0, 0, 0, 0, 0, 0,                   1, 0, 0, 0, 0, 0);
    row(0, 0, 0, 0, 0, 0, 0, 0, 1, 'hFFFFFFFF,             1, 0, 0, 0, 0, 0);
    idle_row(0, 0, 0);
    row(0, 1, 'h40, 0, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 0, 1, 0);
    e_maddr = 'h40;
    row(0, 1, 'h40, 0, 0, 0, 0, 0, 1, 'h11111111,          1, 0, 0, 0, 1, 0);
    e_ir = 'h11111111;
    row(0, 1, 'h40, 0, 0, 0, 0, 0, 0, 0,                   0, 0, 1, 0, 0, 0);
    idle_row(0, 0, 0);
    // Reset in the middle of a load, then a clean fetch.
    row(0, 0, 0, 0, 1, 0, 'h300, 0, 0, 0,                  0, 0, 0, 0, 0, 1);
    e_maddr = 'h300; e_mwd = 0;
    row(0, 0, 0, 0, 1, 0, 'h300, 0, 0, 0,                  1, 0, 0, 0, 0, 1);
    e_maddr = 0; e_mwd = 0; e_ir = 0; e_dr = 0;
    row(1, 0, 0, 0, 1, 0, 'h300, 0, 0, 0,                  0, 0, 0, 0, 0, 1);
    row(0, 1, 'h44, 0, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 0, 1, 0);
    e_maddr = 'h44;
    row(0, 1, 'h44, 0, 0, 0, 0, 0, 1, 'h22222222,          1, 0, 0, 0, 1, 0);
    e_ir = 'h22222222;
    row(0, 1, 'h44, 0, 0, 0, 0, 0, 0, 0,                   0, 0, 1, 0, 0, 0);
    idle_row(0, 0, 0);

    foreach (vecs[i]) begin
      rst           = vecs[i].rst;
      bus.if_req    = vecs[i].ireq;
      bus.if_addr   = vecs[i].iaddr;
      bus.if_abort  = vecs[i].iab;
      bus.dm_req    = vecs[i].dreq;
      bus.dm_we     = vecs[i].dwe;
      bus.dm_addr   = vecs[i].daddr;
      bus.dm_wdata  = vecs[i].dwd;
      bus.mem_ready = vecs[i].rdy;
      bus.mem_rdata = vecs[i].rdata;
      @(negedge clk);
      chk1($sformatf("v%0d mem_en", i),    bus.mem_en,    vecs[i].en);
      chk1($sformatf("v%0d mem_we", i),    bus.mem_we,    vecs[i].we);
      chk1($sformatf("v%0d if_ack", i),    bus.if_ack,    vecs[i].ia);
      chk1($sformatf("v%0d dm_ack", i),    bus.dm_ack,    vecs[i].da);
      chk1($sformatf("v%0d stall_F", i),   bus.stall_F,   vecs[i].sf);
      chk1($sformatf("v%0d stall_M", i),   bus.stall_M,   vecs[i].sm);
      chk32($sformatf("v%0d mem_addr", i), bus.mem_addr,  vecs[i].maddr);
      chk32($sformatf("v%0d mem_wdata", i), bus.mem_wdata, vecs[i].mwd);
      chk32($sformatf("v%0d if_rdata", i), bus.if_rdata,  vecs[i].ir);
      chk32($sformatf("v%0d dm_rdata", i), bus.dm_rdata,  vecs[i].dr);
      @(posedge clk);
      #1;
    end

    // Randomized traffic.
    rst = 1'b1;
    bus.if_req = 0; bus.if_abort = 0; bus.dm_req = 0; bus.mem_ready = 0;
    for (int k = 0; k < 256; k++) begin
      tmem[k]    = $urandom;
      ref_mem[k] = tmem[k];
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    f_pend = 0; d_pend = 0; d_block = 0; prev_en = 0; prev_dreq = 0; done = 0;
    f_addr = 0; d_addr = 0; d_wd = 0; d_we = 0; exp_ir = 0; exp_dr = 0;
    p_addr = 0; p_wd = 0; p_we = 0; f_wait = 0; d_wait = 0;

    for (int c = 0; c < 4000 && !done; c++) begin
      bus.if_abort = 1'b0;
      if (f_pend) begin
        if ($urandom_range(15) == 0) bus.if_abort = 1'b1;
      end else if ($urandom_range(2) == 0) begin
        f_pend = 1; f_addr = {22'd0, 8'($urandom), 2'b00}; f_wait = 0;
      end
      bus.if_req  = f_pend;
      bus.if_addr = f_addr;
      if (!d_pend && !d_block && $urandom_range(2) == 0) begin
        d_pend = 1; d_we = 1'($urandom_range(1));
        d_addr = {22'd0, 8'($urandom), 2'b00}; d_wd = $urandom; d_wait = 0;
      end
      d_block = 0;
      bus.dm_req = d_pend; bus.dm_we = d_we; bus.dm_addr = d_addr; bus.dm_wdata = d_wd;
      if (bus.mem_en) begin
        bus.mem_ready = 1'($urandom_range(1));
        bus.mem_rdata = bus.mem_ready ? tmem[bus.mem_addr[9:2]] : $urandom;
      end else begin
        bus.mem_ready = ($urandom_range(3) == 0);
        bus.mem_rdata = $urandom;
      end

      @(negedge clk);
      chk1("rnd stall_F", bus.stall_F, bus.if_req & ~bus.if_ack & ~bus.if_abort);
      chk1("rnd stall_M", bus.stall_M, bus.dm_req & ~bus.dm_ack);
      chk1("rnd ack overlap", bus.if_ack & bus.dm_ack, 1'b0);
      if (bus.mem_en && prev_en) begin
        chk32("rnd mem_addr stable", bus.mem_addr, p_addr);
        chk32("rnd mem_wdata stable", bus.mem_wdata, p_wd);
        chk1("rnd mem_we stable", bus.mem_we, p_we);
      end
      if (bus.mem_en && !prev_en) begin
        if (bus.mem_we)
          chk_ok("rnd store grant", d_pend && d_we && bus.mem_addr == d_addr && bus.mem_wdata == d_wd);
        else
          chk_ok("rnd read grant", (d_pend && !d_we && bus.mem_addr == d_addr) || (f_pend && bus.mem_addr == f_addr));
`ifndef ARB_ROUND_ROBIN_EN
        if (prev_dreq)
          chk_ok("rnd data priority", bus.mem_addr == d_addr && bus.mem_we == d_we);
`endif
      end
      if (bus.if_ack) begin
        chk_ok("rnd if_ack expected", f_pend);
        exp_ir = ref_mem[f_addr[9:2]];
        chk32("rnd if_rdata", bus.if_rdata, exp_ir);
        f_pend = 0;
      end else begin
        chk32("rnd if_rdata hold", bus.if_rdata, exp_ir);
        if (bus.if_abort) f_pend = 0;
      end
      if (bus.dm_ack) begin
        chk_ok("rnd dm_ack expected", d_pend);
        if (!d_we) begin
          exp_dr = ref_mem[d_addr[9:2]];
          chk32("rnd dm_rdata load", bus.dm_rdata, exp_dr);
        end else begin
          chk32("rnd dm_rdata store", bus.dm_rdata, exp_dr);
          ref_mem[d_addr[9:2]] = d_wd;
        end
        d_pend = 0; d_block = 1;
      end else begin
        chk32("rnd dm_rdata hold", bus.dm_rdata, exp_dr);
      end
      if (bus.mem_en && bus.mem_ready && bus.mem_we)
        tmem[bus.mem_addr[9:2]] = bus.mem_wdata;
      if (f_pend) f_wait++;
      if (d_pend) d_wait++;
      if (f_wait > 200 || d_wait > 200) begin
        n_checks++;
        n_errors++;
        $display("FAIL rnd timeout: got wait f=%0d d=%0d expected at most 200", f_wait, d_wait);
        done = 1;
      end
      prev_en = bus.mem_en; p_addr = bus.mem_addr; p_wd = bus.mem_wdata; p_we = bus.mem_we;
      prev_dreq = bus.dm_req;
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
